ex_muldiv_sequencer: RTL and testbench

//  Multi-cycle controller for RV32M MUL/DIV ops alongside the single-cycle EX ALU.

---
 rtl/ex_muldiv_sequencer_pkg.sv | 42 ++++
 rtl/muldiv_step.sv | 47 ++++
 rtl/ex_muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
//   - ALU operation codes (existing single-cycle codes plus the RV32M group)
//   - sequencer FSM state encoding
//   - small decode helpers for the RV32M code group
package ex_muldiv_sequencer_pkg;

  localparam int unsigned AluCtrlW = 6;

  // Existing single-cycle ALU codes
  localparam logic [AluCtrlW-1:0] ALU_ADD  = 6'h00;
  localparam logic [AluCtrlW-1:0] ALU_SUB  = 6'h01;
  localparam logic [AluCtrlW-1:0] ALU_AND  = 6'h02;
  localparam logic [AluCtrlW-1:0] ALU_OR   = 6'h03;
  localparam logic [AluCtrlW-1:0] ALU_XOR  = 6'h04;
  localparam logic [AluCtrlW-1:0] ALU_JAL  = 6'h10;
  localparam logic [AluCtrlW-1:0] ALU_JALR = 6'h11;

  // RV32M group: codes 6'b100xxx; bit 2 selects the divide family
  localparam logic [AluCtrlW-1:0] ALU_MUL    = 6'h20;
  localparam logic [AluCtrlW-1:0] ALU_MULH   = 6'h21;
  localparam logic [AluCtrlW-1:0] ALU_MULHSU = 6'h22;
  localparam logic [AluCtrlW-1:0] ALU_MULHU  = 6'h23;
  localparam logic [AluCtrlW-1:0] ALU_DIV    = 6'h24;
  localparam logic [AluCtrlW-1:0] ALU_DIVU   = 6'h25;
  localparam logic [AluCtrlW-1:0] ALU_REM    = 6'h26;
  localparam logic [AluCtrlW-1:0] ALU_REMU   = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [AluCtrlW-1:0] code);
    return code[5:3] == 3'b100;
  endfunction

  function automatic logic is_div_family(input logic [AluCtrlW-1:0] code);
    return is_muldiv(code) && code[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration of the shared multiply/divide datapath.
//   is_div   : 0 = shift-add multiply step, 1 = restoring divide step
//   hi       : multiply -> upper product half (bit XLEN is a spare carry, always 0)
//              divide   -> XLEN+1-bit partial remainder
//   lo       : multiply -> lower product half / remaining multiplier bits
//              divide   -> dividend bits (MSB first) / quotient bits (shifted in at LSB)
//   opnd     : multiplicand or divisor magnitude
//   hi_next, lo_next : register values after this step
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN:0]   hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN:0]   hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] addend;
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    addend  = lo[0] ? {1'b0, opnd} : '0;
    sum     = hi + addend;
    shifted = {hi[XLEN-1:0], lo[XLEN-1]};
    // Borrow out of the XLEN+1-bit subtract means shifted < divisor: restore.
    trial   = shifted - {1'b0, opnd};

    if (is_div) begin
      if (trial[XLEN]) begin
        hi_next = shifted;
        lo_next = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_next = trial;
        lo_next = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      // Carry of the add drops into the top of the product as it shifts right.
      hi_next = {1'b0, sum[XLEN:1]};
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M controller sitting beside the single-cycle EX ALU.
// Accepts an op on the issue strobe, stalls the upstream pipeline while it iterates
// one radix-2 step per cycle, and returns a registered result with a one-cycle pulse.
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-high reset
//   start          : issue strobe, only looked at in IDLE
//   ALU_Control    : op code; only the RV32M group is accepted
//   operand_A/B    : rs1 / rs2 values
//   flush          : kill from a taken jump/branch; aborts an op in flight
//   stall          : freeze IF/ID/EX (accept cycle and every CALC cycle)
//   result_valid   : one-cycle pulse while in DONE
//   result         : final value, held until overwritten by the next completed op
module ex_muldiv_sequencer
  import ex_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      ALU_Control,
  input  logic [XLEN-1:0] operand_A,
  input  logic [XLEN-1:0] operand_B,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CntW    = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] CntInit = CntW'(XLEN);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [XLEN-1:0] IntMin  = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  // Issue-side decode
  logic            accept;
  logic            sign_a_en, sign_b_en;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            acc_div, acc_rem;
  logic            b_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_val;

  // Completion-side fix-up
  logic [XLEN:0]     hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_val;

  assign accept = (state_q == ST_IDLE) && start && is_muldiv(ALU_Control) && !flush;

  always_comb begin
    sign_a_en = 1'b0;
    sign_b_en = 1'b0;
    unique case (ALU_Control)
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
        sign_a_en = 1'b1;
        sign_b_en = 1'b1;
      end
      ALU_MULHSU: sign_a_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sa      = sign_a_en && operand_A[XLEN-1];
    sb      = sign_b_en && operand_B[XLEN-1];
    mag_a   = sa ? -operand_A : operand_A;
    mag_b   = sb ? -operand_B : operand_B;
    acc_div = is_div_family(ALU_Control);
    acc_rem = acc_div && ALU_Control[1];
    b_zero  = (operand_B == '0);
    div_ovf = ((ALU_Control == ALU_DIV) || (ALU_Control == ALU_REM)) &&
              (operand_A == IntMin) && (operand_B == '1);
    fast    = acc_div && (b_zero || div_ovf);
    if (b_zero) begin
      fast_val = acc_rem ? operand_A : '1;
    end else begin
      fast_val = acc_rem ? '0 : IntMin;
    end
  end

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div (op_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_next(hi_n),
    .lo_next(lo_n)
  );

  // The last step's outputs feed the result directly so the pulse lands one cycle
  // after the final iteration.
  always_comb begin
    prod     = {hi_n[XLEN-1:0], lo_n};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_n : lo_n;
    rem_fix  = neg_q ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
    unique case (op_q)
      ALU_MUL:                          final_val = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                final_val = quo_fix;
      default:                          final_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opnd_d       = opnd_q;
    neg_d        = neg_q;
    result_d     = result_q;
    stall        = 1'b0;
    result_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          op_d  = ALU_Control;
          // Remainder takes the dividend's sign; everything else takes sA^sB.
          neg_d = acc_rem ? sa : (sa ^ sb);
          if (fast) begin
            state_d  = ST_DONE;
            result_d = fast_val;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CntInit;
            hi_d    = '0;
            lo_d    = acc_div ? mag_a : mag_b;
            opnd_d  = acc_div ? mag_b : mag_a;
          end
        end
      end
      ST_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d  = ST_DONE;
            result_d = final_val;
          end
        end
      end
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;
  import ex_muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        flush;
  logic        stall, result_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  ex_muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .start       (start),
    .ALU_Control (alu_control),
    .operand_A   (operand_a),
    .operand_B   (operand_b),
    .flush       (flush),
    .stall       (stall),
    .result_valid(result_valid),
    .result      (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_MUL:    begin p = {32'b0, a} * {32'b0, b};                 return p[31:0];  end
      ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     return p[63:32]; end
      ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};           return p[63:32]; end
      ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b};                 return p[63:32]; end
      ALU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                  else if (ovf) return a;
                  else return $signed(a) / $signed(b);
      ALU_DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      ALU_REM:    if (b == 0) return a;
                  else if (ovf) return 32'h0;
                  else return $signed(a) % $signed(b);
      default:    if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if ((op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU) && b == 0)
      return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Called just after a negedge. Issues one op and checks latency, stall length,
  // value, pulse width and hold. Returns just after the negedge of the IDLE cycle
  // following DONE, so a following call issues back-to-back.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int vcyc;
    int scnt;
    start       = 1'b1;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    #1;
    scnt = stall ? 1 : 0;
    vcyc = 0;
    for (int k = 1; k <= 40 && vcyc == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (result_valid) vcyc = k;
      else if (stall) scnt++;
    end
    check({tag, "_latency"}, 32'(vcyc), 32'(lat));
    check({tag, "_stall_cycles"}, 32'(scnt), 32'(lat));
    check({tag, "_result"}, result, exp);
    @(negedge clk);
    #1;
    check({tag, "_pulse_width"}, {31'b0, result_valid}, 32'h0);
    check({tag, "_hold"}, result, exp);
  endtask

  vec_t        vecs[14];
  logic [31:0] prev_exp;
  logic [31:0] ra, rb;
  logic [5:0]  rop;
  int          seen;
  int          stall_seen;

  initial begin
    vecs[0]  = '{ALU_MUL,    32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{ALU_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[2]  = '{ALU_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[3]  = '{ALU_DIVU,   32'd7,          32'd2,          32'd3,          33};
    vecs[4]  = '{ALU_REMU,   32'd7,          32'd2,          32'd1,          33};
    vecs[5]  = '{ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          33};
    vecs[6]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
    vecs[7]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[8]  = '{ALU_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{ALU_REM,    32'd5,          32'd0,          32'd5,          1};
    vecs[10] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vecs[12] = '{ALU_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[13] = '{ALU_MUL,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};

    rst         = 1'b1;
    start       = 1'b0;
    alu_control = ALU_ADD;
    operand_a   = '0;
    operand_b   = '0;
    flush       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_valid", {31'b0, result_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Directed table, issued back-to-back
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat);
    end
    prev_exp = vecs[13].exp;

    // Flush at CALC step 10: no pulse, result keeps its old value
    start = 1'b1; alu_control = ALU_MUL; operand_a = 32'd7; operand_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall_drop", {31'b0, stall}, 32'h0);
    seen = 0;
    if (result_valid) seen = 1;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (result_valid) seen = 1;
    end
    check("flush_no_pulse", 32'(seen), 32'h0);
    check("flush_result_held", result, prev_exp);
    run_op("after_flush", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Reset asserted mid-CALC
    start = 1'b1; alu_control = ALU_MULHU; operand_a = 32'hFFFF_FFFF; operand_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_stall", {31'b0, stall}, 32'h0);
    check("midreset_valid", {31'b0, result_valid}, 32'h0);
    check("midreset_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Non-M code is ignored; nothing from the killed op reappears
    start = 1'b1; alu_control = ALU_ADD; operand_a = 32'd1; operand_b = 32'd2;
    seen = 0;
    stall_seen = 0;
    repeat (40) begin
      #1;
      if (result_valid) seen = 1;
      if (stall) stall_seen = 1;
      @(negedge clk);
    end
    start = 1'b0;
    check("add_ignored_stall", 32'(stall_seen), 32'h0);
    check("after_reset_no_pulse", 32'(seen), 32'h0);
    check("after_reset_result", result, 32'h0);
    #1;

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = ALU_MUL + 6'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'h0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 30); end
        3: begin ra = 32'd0 - $urandom_range(1, 1000); rb = $urandom_range(1, 30); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op($sformatf("rand%0d_op%0h_%h_%h", i, rop, ra, rb), rop, ra, rb,
             ref_result(rop, ra, rb), ref_latency(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
